alu_seq_nbit: RTL and testbench
===============================

Name: alu_seq_nbit

Overview:
Registered, parametrised N-bit ALU with a start/done handshake, an internal accumulator and a status-flag register.
Extends the 8-operation combinational ALU to 16 operations:
- shifts and rotate
- compare
- load and clear
- a multi-cycle unsigned shift-add multiply producing a 2N-bit product

It sits between the control FSM and the register file. Results and flags hold until the next accepted operation.

Parameters:
N, 8, operand/result width (N >= 2)
MUL_EN, 1, 1 = multiply implemented; 0 = mode 12 returns zero in one cycle

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
A  in  N  operand A
B  in  N  operand B
CB_in  in  1  carry/borrow in (modes 0, 1)
mode  in  4  operation select
use_acc  in  1  1 = operand A is replaced by the current res register
busy  out  1  high while a multiply is iterating
done  out  1  one-cycle pulse when res/flags are updated
res  out  N  result low word / accumulator
res_hi  out  N  product high word (mode 12 only; otherwise 0)
CB_out  out  1  carry (add/inc/shift) or borrow (sub/dec/cmp)
zero  out  1  result == 0
neg  out  1  result MSB
ovf  out  1  signed overflow

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state=IDLE; busy, done, res, res_hi, CB_out, zero, neg, ovf all 0.
- States: IDLE, MUL.
- Start rules:
  - start=1 in IDLE at edge k with mode != 12 (or MUL_EN=0): result is registered at edge k; done=1 for that following cycle; state stays IDLE.
  - start=1 in IDLE with mode 12 and MUL_EN=1: operands latch at edge k and the state goes to MUL; busy=1 from edge k.
  - MUL performs one shift-add per edge over N edges (k+1..k+N).
  - At edge k+N: {res_hi,res} = product, done=1, busy=0, state returns to IDLE.
- start while busy=1 is ignored; operands are not re-sampled.
- start held high in IDLE starts a new operation every cycle (back-to-back allowed).
- Operand A = use_acc ? res : A. The value is sampled at start.
- Modes. All arithmetic is modulo 2^N. res_hi=0 except in mode 12.
  - 0 ADD: {CB_out,res} = A+B+CB_in.
  - 1 SUB: res = A+CB_in-B; CB_out=1 if (A+CB_in) < B.
  - 2 AND, 3 OR, 4 XOR, 5 NOT A: CB_out=0.
  - 6 INC: CB_out=1 when A=all-ones.
  - 7 DEC: CB_out=1 when A=0.
  - 8 SHL: CB_out=A[N-1].
  - 9 SHR (logical): CB_out=A[0].
  - 10 ASR: CB_out=A[0].
  - 11 ROL: res={A[N-2:0],A[N-1]}; CB_out=A[N-1].
  - 12 MUL: unsigned; CB_out=0.
  - 13 CMP: flags from A-B (borrow into CB_out); res and res_hi hold their values.
  - 14 LDB: res=B.
  - 15 CLR: res=0.
- Flags, all updated only with done:
  - zero: 1 if res==0; for MUL, 1 if the full 2N-bit product is 0.
  - neg: res[N-1]; for MUL, res_hi[N-1].
  - ovf: signed overflow for modes 0, 1, 6, 7, 13; 0 for all other modes.
- Reset asserted mid-multiply aborts it immediately: all outputs return to reset values and done is not produced.
- MUL_EN=0: mode 12 completes in one cycle with res=res_hi=0, zero=1, CB_out=0.

Decomposition:
- Package alu_seq_pkg holds:
  - the 4-bit mode constants (MODE_ADD..MODE_CLR)
  - the state encoding (ST_IDLE, ST_MUL)
- Sub-module alu_shift_add_mul (N-bit iterative unsigned multiplier with load/step/count) is generated only when MUL_EN=1.
- The single-cycle datapath stays in the top level.

Test Plan:
1. N=8, ADD A=200 B=100 CB_in=1 -> one cycle later done=1, res=45, CB_out=1, ovf=0, neg=0.
2. SUB A=5 B=7 CB_in=0 -> res=254, CB_out=1, neg=1. Then ADD A=127 B=1 -> res=128, ovf=1, neg=1.
3. MUL A=255 B=255 -> busy high for 8 cycles, then done; res_hi=0xFE, res=0x01, zero=0. A second start at cycle 3 (mode 0) is ignored and gives no extra done.
4. LDB B=10, then ADD use_acc=1 B=5 -> res=15. Then CMP use_acc=1 B=15 -> zero=1, CB_out=0, res stays 15.
5. Shifts with A=0x81: SHL -> 0x02/CB=1; SHR -> 0x40/CB=1; ASR -> 0xC0/CB=1; ROL -> 0x03/CB=1.
6. rst_n low during MUL cycle 4 -> busy, done, res, res_hi and all flags 0 immediately. After release, MUL 3*4 -> res=12 after 8 cycles.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: mode codes and FSM state encoding shared by the sequential ALU
package alu_seq_pkg;
    localparam logic [3:0] MODE_ADD = 4'd0;
    localparam logic [3:0] MODE_SUB = 4'd1;
    localparam logic [3:0] MODE_AND = 4'd2;
    localparam logic [3:0] MODE_OR  = 4'd3;
    localparam logic [3:0] MODE_XOR = 4'd4;
    localparam logic [3:0] MODE_NOT = 4'd5;
    localparam logic [3:0] MODE_INC = 4'd6;
    localparam logic [3:0] MODE_DEC = 4'd7;
    localparam logic [3:0] MODE_SHL = 4'd8;
    localparam logic [3:0] MODE_SHR = 4'd9;
    localparam logic [3:0] MODE_ASR = 4'd10;
    localparam logic [3:0] MODE_ROL = 4'd11;
    localparam logic [3:0] MODE_MUL = 4'd12;
    localparam logic [3:0] MODE_CMP = 4'd13;
    localparam logic [3:0] MODE_LDB = 4'd14;
    localparam logic [3:0] MODE_CLR = 4'd15;
    typedef enum logic {ST_IDLE, ST_MUL} state_t;
endpackage

// File: rtl/alu_shift_add_mul.sv
// alu_shift_add_mul: N-step iterative unsigned shift-add multiplier
module alu_shift_add_mul #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] prod_nxt,
    output logic           last
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    logic [N-1:0]   mcand;
    logic [2*N-1:0] p;
    logic [CW-1:0]  cnt;
    logic [N:0]     sum;
    // Conditionally add the multiplicand to the high half, then shift right one place
    always_comb begin
        sum      = {1'b0, p[2*N-1:N]} + (p[0] ? {1'b0, mcand} : '0);
        prod_nxt = {sum, p[N-1:1]};
        last     = cnt == CW'(N - 1);
    end
    // Operand latch on load, one partial-product step per cycle afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            p     <= '0;
            cnt   <= '0;
        end else if (load) begin
            mcand <= a;
            p     <= {{N{1'b0}}, b};
            cnt   <= '0;
        end else if (step) begin
            p     <= prod_nxt;
            cnt   <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/alu_seq_nbit.sv
// alu_seq_nbit: registered 16-op N-bit ALU with accumulator, flags and iterative multiply
module alu_seq_nbit #(
    parameter int N      = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CB_in,
    input  logic [3:0]   mode,
    input  logic         use_acc,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] res,
    output logic [N-1:0] res_hi,
    output logic         CB_out,
    output logic         zero,
    output logic         neg,
    output logic         ovf
);
    import alu_seq_pkg::*;
    localparam logic [N+1:0] ONE = (N + 2)'(1);
    state_t         state, state_nxt;
    logic [N-1:0]   op_a, r;
    logic [N+1:0]   za, zb, sa, sb, ci, u, s;
    logic           cb_c, arith, ovf_c, start_mul, mul_last;
    logic [2*N-1:0] mul_prod;

    assign op_a      = use_acc ? res : A;
    assign za        = {2'b00, op_a};
    assign zb        = {2'b00, B};
    assign sa        = {{2{op_a[N-1]}}, op_a};
    assign sb        = {{2{B[N-1]}}, B};
    assign ci        = (N + 2)'(CB_in);
    assign busy      = state == ST_MUL;
    assign start_mul = MUL_EN && start && state == ST_IDLE && mode == MODE_MUL;

    if (MUL_EN) begin : g_mul
        alu_shift_add_mul #(.N(N)) u_mul (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (start_mul),
            .step     (busy),
            .a        (op_a),
            .b        (B),
            .prod_nxt (mul_prod),
            .last     (mul_last)
        );
    end else begin : g_nomul
        assign mul_prod = '0;
        assign mul_last = 1'b0;
    end

    // Single-cycle datapath: u is the zero-extended result, s the exact signed one
    always_comb begin
        u     = '0;
        s     = '0;
        r     = '0;
        cb_c  = 1'b0;
        arith = 1'b0;
        case (mode)
            MODE_ADD: begin u = za + zb + ci; s = sa + sb + ci; r = u[N-1:0]; cb_c = u[N];   arith = 1'b1; end
            MODE_SUB: begin u = za + ci - zb; s = sa + ci - sb; r = u[N-1:0]; cb_c = u[N+1]; arith = 1'b1; end
            MODE_AND: r = op_a & B;
            MODE_OR:  r = op_a | B;
            MODE_XOR: r = op_a ^ B;
            MODE_NOT: r = ~op_a;
            MODE_INC: begin u = za + ONE; s = sa + ONE; r = u[N-1:0]; cb_c = u[N];   arith = 1'b1; end
            MODE_DEC: begin u = za - ONE; s = sa - ONE; r = u[N-1:0]; cb_c = u[N+1]; arith = 1'b1; end
            MODE_SHL: begin r = {op_a[N-2:0], 1'b0};      cb_c = op_a[N-1]; end
            MODE_SHR: begin r = {1'b0, op_a[N-1:1]};      cb_c = op_a[0];   end
            MODE_ASR: begin r = {op_a[N-1], op_a[N-1:1]}; cb_c = op_a[0];   end
            MODE_ROL: begin r = {op_a[N-2:0], op_a[N-1]}; cb_c = op_a[N-1]; end
            MODE_CMP: begin u = za - zb; s = sa - sb; r = u[N-1:0]; cb_c = u[N+1]; arith = 1'b1; end
            MODE_LDB: r = B;
            default:  r = '0;
        endcase
        ovf_c = arith && (s != {{2{s[N-1]}}, s[N-1:0]});
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: enter MUL on an accepted multiply, leave after the last step
    always_comb begin
        state_nxt = state;
        if (start_mul)             state_nxt = ST_MUL;
        else if (busy && mul_last) state_nxt = ST_IDLE;
    end

    // Result and flag registers; CMP updates flags only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            res    <= '0;
            res_hi <= '0;
            CB_out <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
        end else if (busy) begin
            done <= mul_last;
            if (mul_last) begin
                {res_hi, res} <= mul_prod;
                CB_out        <= 1'b0;
                zero          <= mul_prod == '0;
                neg           <= mul_prod[2*N-1];
                ovf           <= 1'b0;
            end
        end else begin
            done <= start && !start_mul;
            if (start && !start_mul) begin
                if (mode != MODE_CMP) begin
                    res    <= r;
                    res_hi <= '0;
                end
                CB_out <= cb_c;
                zero   <= r == '0;
                neg    <= r[N-1];
                ovf    <= ovf_c;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_nbit.sv
// tb_alu_seq_nbit: directed vectors with a scoreboard checked on every done pulse
module tb_alu_seq_nbit;
    import alu_seq_pkg::*;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, CB_in = 1'b0, use_acc = 1'b0;
    logic [3:0] mode = '0;
    logic [7:0] A = '0, B = '0;
    logic       busy, done, CB_out, zero, neg, ovf;
    logic [7:0] res, res_hi;

    typedef struct {
        string      nm;
        logic [7:0] r;
        logic [7:0] rh;
        logic       cb;
        logic       z;
        logic       n;
        logic       v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    alu_seq_nbit #(.N(8), .MUL_EN(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .CB_in   (CB_in),
        .mode    (mode),
        .use_acc (use_acc),
        .busy    (busy),
        .done    (done),
        .res     (res),
        .res_hi  (res_hi),
        .CB_out  (CB_out),
        .zero    (zero),
        .neg     (neg),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got done res=%h res_hi=%h expected no done", res, res_hi);
            end else begin
                e = sb.pop_front();
                if ({res, res_hi, CB_out, zero, neg, ovf} !== {e.r, e.rh, e.cb, e.z, e.n, e.v}) begin
                    fails++;
                    $display("FAIL %s: got res=%h hi=%h cb=%b z=%b n=%b v=%b expected res=%h hi=%h cb=%b z=%b n=%b v=%b",
                             e.nm, res, res_hi, CB_out, zero, neg, ovf, e.r, e.rh, e.cb, e.z, e.n, e.v);
                end
            end
        end
    end

    task automatic issue(input string nm, input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic acc, input logic [7:0] er, input logic [7:0] erh,
                         input logic ecb, input logic ez, input logic en, input logic ev, input bit push);
        mode    = m;
        A       = a;
        B       = b;
        CB_in   = ci;
        use_acc = acc;
        start   = 1'b1;
        if (push) sb.push_back('{nm, er, erh, ecb, ez, en, ev});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_mul(input int want, input bit poke);
        int c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            c++;
            if (poke && c == 3) begin
                mode    = MODE_ADD;
                A       = 8'd1;
                B       = 8'd1;
                use_acc = 1'b0;
                start   = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        chk("mul_busy_cycles", c, want);
    endtask

    initial begin
        #12;
        chk("reset_outputs", {busy, done, res, res_hi, CB_out, zero, neg, ovf}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue("add_carry",  MODE_ADD, 8'd200, 8'd100, 1'b1, 1'b0, 8'h2D, 8'h00, 1, 0, 0, 0, 1);
        issue("sub_borrow", MODE_SUB, 8'd5,   8'd7,   1'b0, 1'b0, 8'hFE, 8'h00, 1, 0, 1, 0, 1);
        issue("add_ovf",    MODE_ADD, 8'd127, 8'd1,   1'b0, 1'b0, 8'h80, 8'h00, 0, 0, 1, 1, 1);
        issue("mul_ff_ff",  MODE_MUL, 8'hFF,  8'hFF,  1'b0, 1'b0, 8'h01, 8'hFE, 0, 0, 1, 0, 1);
        wait_mul(8, 1'b1);
        issue("ldb",        MODE_LDB, 8'h00,  8'd10,  1'b0, 1'b0, 8'h0A, 8'h00, 0, 0, 0, 0, 1);
        issue("add_acc",    MODE_ADD, 8'h00,  8'd5,   1'b0, 1'b1, 8'h0F, 8'h00, 0, 0, 0, 0, 1);
        issue("cmp_equal",  MODE_CMP, 8'h00,  8'd15,  1'b0, 1'b1, 8'h0F, 8'h00, 0, 1, 0, 0, 1);
        issue("shl",        MODE_SHL, 8'h81,  8'h00,  1'b0, 1'b0, 8'h02, 8'h00, 1, 0, 0, 0, 1);
        issue("shr",        MODE_SHR, 8'h81,  8'h00,  1'b0, 1'b0, 8'h40, 8'h00, 1, 0, 0, 0, 1);
        issue("asr",        MODE_ASR, 8'h81,  8'h00,  1'b0, 1'b0, 8'hC0, 8'h00, 1, 0, 1, 0, 1);
        issue("rol",        MODE_ROL, 8'h81,  8'h00,  1'b0, 1'b0, 8'h03, 8'h00, 1, 0, 0, 0, 1);
        issue("and",        MODE_AND, 8'hF0,  8'h3C,  1'b0, 1'b0, 8'h30, 8'h00, 0, 0, 0, 0, 1);
        issue("or",         MODE_OR,  8'hF0,  8'h0F,  1'b0, 1'b0, 8'hFF, 8'h00, 0, 0, 1, 0, 1);
        issue("xor_zero",   MODE_XOR, 8'hAA,  8'hAA,  1'b0, 1'b0, 8'h00, 8'h00, 0, 1, 0, 0, 1);
        issue("not",        MODE_NOT, 8'h0F,  8'h00,  1'b0, 1'b0, 8'hF0, 8'h00, 0, 0, 1, 0, 1);
        issue("sub_cin",    MODE_SUB, 8'h00,  8'h01,  1'b1, 1'b0, 8'h00, 8'h00, 0, 1, 0, 0, 1);
        issue("cmp_ovf",    MODE_CMP, 8'h80,  8'h01,  1'b0, 1'b0, 8'h00, 8'h00, 0, 0, 0, 1, 1);
        issue("ldb_55",     MODE_LDB, 8'h00,  8'h55,  1'b0, 1'b0, 8'h55, 8'h00, 0, 0, 0, 0, 1);
        issue("clr",        MODE_CLR, 8'hFF,  8'hFF,  1'b1, 1'b0, 8'h00, 8'h00, 0, 1, 0, 0, 1);
        issue("inc_wrap",   MODE_INC, 8'hFF,  8'h00,  1'b0, 1'b0, 8'h00, 8'h00, 1, 1, 0, 0, 1);
        issue("inc_ovf",    MODE_INC, 8'h7F,  8'h00,  1'b0, 1'b0, 8'h80, 8'h00, 0, 0, 1, 1, 1);
        issue("dec_wrap",   MODE_DEC, 8'h00,  8'h00,  1'b0, 1'b0, 8'hFF, 8'h00, 1, 0, 1, 0, 1);
        issue("dec_ovf",    MODE_DEC, 8'h80,  8'h00,  1'b0, 1'b0, 8'h7F, 8'h00, 0, 0, 0, 1, 1);
        issue("mul_abort",  MODE_MUL, 8'hFF,  8'hFF,  1'b0, 1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("busy_before_abort", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, res, res_hi, CB_out, zero, neg, ovf}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        chk("busy_after_release", {31'b0, busy}, 0);
        @(posedge clk);
        #1;
        issue("mul_3_4",    MODE_MUL, 8'd3,   8'd4,   1'b0, 1'b0, 8'h0C, 8'h00, 0, 0, 0, 0, 1);
        wait_mul(8, 1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end of run expected finish before 20000");
        $fatal(1);
    end
endmodule
